// File: rtl/auth_msg_tx_serializer_pkg.sv
// Shared constants and state encoding for the auth message TX serializer.
package auth_msg_tx_serializer_pkg;

  localparam int unsigned MSG_LEN_DEFAULT = 2080;
  localparam logic [7:0]  SYNC_DEFAULT    = 8'hD5;
  localparam int unsigned EOP_BITS        = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHECK   = 3'd3,
    ST_EOP     = 3'd4
  } tx_state_e;

endpackage

// File: rtl/auth_msg_tx_serializer_bit_timer.sv
// Bit-period divider: div_cnt runs 0..BIT_DIV-1 and bit_tick marks the wrap cycle.
module auth_bit_timer #(
  parameter int unsigned BIT_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic bit_tick
);

  localparam int unsigned DW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(BIT_DIV - 1);

  logic [DW-1:0] div_cnt_q, div_cnt_d;

  always_comb begin
    div_cnt_d = div_cnt_q;
    bit_tick  = 1'b0;
    if (clear) begin
      div_cnt_d = '0;
    end else if (enable) begin
      if (div_cnt_q == LAST) begin
        div_cnt_d = '0;
        bit_tick  = 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) div_cnt_q <= '0;
    else       div_cnt_q <= div_cnt_d;
  end

endmodule

// File: rtl/auth_msg_tx_serializer.sv
// Serializes one parallel auth message as SYNC, payload, XOR checksum and SE1 EOP
// on the TX2 differential pair, acknowledging the controller on capture.
module auth_msg_tx_serializer
  import auth_msg_tx_serializer_pkg::*;
#(
  parameter int unsigned MSG_LEN = auth_msg_tx_serializer_pkg::MSG_LEN_DEFAULT,
  parameter int unsigned BIT_DIV = 4,
  parameter logic [7:0]  SYNC    = auth_msg_tx_serializer_pkg::SYNC_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tx_en,
  input  logic               auth_msg_ready,
  input  logic [MSG_LEN-1:0] auth_msg_out,
  output logic               Ack_in_driver,
  output logic               TX2_p,
  output logic               TX2_m,
  output logic               tx_busy,
  output logic               tx_done,
  output logic               tx_abort
);

  localparam int unsigned BW = $clog2(MSG_LEN);
  localparam logic [BW-1:0] LAST_BYTE_BIT = BW'(7);
  localparam logic [BW-1:0] LAST_PAY_BIT  = BW'(MSG_LEN - 1);
  localparam logic [BW-1:0] LAST_EOP_BIT  = BW'(EOP_BITS - 1);

  tx_state_e          state_q, state_d;
  logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [MSG_LEN-1:0] shift_q, shift_d;
  logic [7:0]         csum_q, csum_d;
  logic               ack_q, ack_d;
  logic               p_q, p_d;
  logic               m_q, m_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               abort_q, abort_d;

  logic       load;
  logic       timer_clear;
  logic       bit_tick;
  logic [7:0] msg_xor;
  logic [7:0] cur_byte;
  logic [2:0] sel;
  logic       tx_bit;

  auth_bit_timer #(.BIT_DIV(BIT_DIV)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (timer_clear),
    .enable   (state_q != ST_IDLE),
    .bit_tick (bit_tick)
  );

  always_comb begin
    msg_xor = '0;
    for (int unsigned i = 0; i < MSG_LEN / 8; i++) begin
      msg_xor = msg_xor ^ auth_msg_out[i*8 +: 8];
    end
  end

  assign load = (state_q == ST_IDLE) && tx_en && auth_msg_ready;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    csum_d      = csum_q;
    ack_d       = 1'b0;
    done_d      = 1'b0;
    abort_d     = 1'b0;
    timer_clear = 1'b0;

    if (state_q == ST_IDLE) begin
      if (load) begin
        state_d     = ST_SYNC;
        bit_cnt_d   = '0;
        shift_d     = auth_msg_out;
        csum_d      = msg_xor;
        ack_d       = 1'b1;
        timer_clear = 1'b1;
      end
    end else if (!tx_en) begin
      state_d     = ST_IDLE;
      bit_cnt_d   = '0;
      abort_d     = 1'b1;
      timer_clear = 1'b1;
    end else if (bit_tick) begin
      unique case (state_q)
        ST_SYNC: begin
          if (bit_cnt_q == LAST_BYTE_BIT) begin
            state_d   = ST_PAYLOAD;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        ST_PAYLOAD: begin
          if (bit_cnt_q == LAST_PAY_BIT) begin
            state_d   = ST_CHECK;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            // The byte being sent always sits at the top; step to the next byte.
            if (bit_cnt_q[2:0] == 3'd7) shift_d = shift_q << 8;
          end
        end
        ST_CHECK: begin
          if (bit_cnt_q == LAST_BYTE_BIT) begin
            state_d   = ST_EOP;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        ST_EOP: begin
          if (bit_cnt_q == LAST_EOP_BIT) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            done_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Line values are derived from the next state so they register alongside it.
  always_comb begin
    cur_byte = shift_d[MSG_LEN-1 -: 8];
    sel      = bit_cnt_d[2:0];
    tx_bit   = 1'b0;
    p_d      = 1'b0;
    m_d      = 1'b0;
    busy_d   = (state_d != ST_IDLE);
    unique case (state_d)
      ST_SYNC:    tx_bit = SYNC[sel];
      ST_PAYLOAD: tx_bit = cur_byte[sel];
      ST_CHECK:   tx_bit = csum_d[sel];
      default:    tx_bit = 1'b0;
    endcase
    if (state_d == ST_EOP) begin
      p_d = 1'b1;
      m_d = 1'b1;
    end else if (state_d != ST_IDLE) begin
      p_d = tx_bit;
      m_d = ~tx_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      csum_q    <= '0;
      ack_q     <= 1'b0;
      p_q       <= 1'b0;
      m_q       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      csum_q    <= csum_d;
      ack_q     <= ack_d;
      p_q       <= p_d;
      m_q       <= m_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
    end
  end

  assign Ack_in_driver = ack_q;
  assign TX2_p         = p_q;
  assign TX2_m         = m_q;
  assign tx_busy       = busy_q;
  assign tx_done       = done_q;
  assign tx_abort      = abort_q;

endmodule

// File: tb/tb_auth_msg_tx_serializer.sv
// Scoreboard bench: stimulus queues expected line values per busy cycle plus
// end-of-frame events; monitors pop and compare as the DUTs present them.
module tb_auth_msg_tx_serializer;

  typedef struct packed {
    logic p;
    logic m;
  } line_t;

  localparam int EV_DONE  = 1;
  localparam int EV_ABORT = 2;
  localparam int FULL     = 100000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        tx_en0, rdy0;
  logic [31:0] msg0;
  logic        ack0, p0, m0, busy0, done0, abort0;

  logic        tx_en1, rdy1;
  logic [7:0]  msg1;
  logic        ack1, p1, m1, busy1, done1, abort1;

  auth_msg_tx_serializer #(.MSG_LEN(32), .BIT_DIV(4), .SYNC(8'hD5)) dut0 (
    .clk(clk), .reset(reset), .tx_en(tx_en0), .auth_msg_ready(rdy0),
    .auth_msg_out(msg0), .Ack_in_driver(ack0), .TX2_p(p0), .TX2_m(m0),
    .tx_busy(busy0), .tx_done(done0), .tx_abort(abort0));

  auth_msg_tx_serializer #(.MSG_LEN(8), .BIT_DIV(1), .SYNC(8'hD5)) dut1 (
    .clk(clk), .reset(reset), .tx_en(tx_en1), .auth_msg_ready(rdy1),
    .auth_msg_out(msg1), .Ack_in_driver(ack1), .TX2_p(p1), .TX2_m(m1),
    .tx_busy(busy1), .tx_done(done1), .tx_abort(abort1));

  int total = 0;
  int bad   = 0;

  line_t q0[$];
  line_t q1[$];
  int    ev0[$];
  int    ev1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected per-cycle line values: SYNC, bytes MSB-byte first (bits LSB first),
  // the given checksum, then two SE1 bit times; truncated after 'limit' cycles.
  task automatic push_frame(input int which, input logic [31:0] msg, input int nbytes,
                            input logic [7:0] csum, input int bdiv, input int limit);
    logic [7:0] sb;
    logic [7:0] byt;
    line_t      bits[$];
    int         n;
    sb = 8'hD5;
    for (int b = 0; b < 8; b++) bits.push_back('{sb[b], ~sb[b]});
    for (int k = nbytes - 1; k >= 0; k--) begin
      byt = msg[k*8 +: 8];
      for (int b = 0; b < 8; b++) bits.push_back('{byt[b], ~byt[b]});
    end
    for (int b = 0; b < 8; b++) bits.push_back('{csum[b], ~csum[b]});
    bits.push_back('{1'b1, 1'b1});
    bits.push_back('{1'b1, 1'b1});
    n = 0;
    foreach (bits[i]) begin
      for (int c = 0; c < bdiv; c++) begin
        if (n < limit) begin
          if (which == 0) q0.push_back(bits[i]);
          else            q1.push_back(bits[i]);
        end
        n++;
      end
    end
  endtask

  always @(negedge clk) begin
    line_t e;
    if (busy0) begin
      if (q0.size() == 0) check("dut0_extra_busy_cycle", 1, 0);
      else begin
        e = q0.pop_front();
        check("dut0_tx_line", {30'd0, p0, m0}, {30'd0, e.p, e.m});
      end
    end
    if (done0 || abort0) begin
      if (ev0.size() == 0) check("dut0_unexpected_event", {done0, abort0}, 0);
      else begin
        int k;
        k = ev0.pop_front();
        check("dut0_event", {done0, abort0}, (k == EV_DONE) ? 2'b10 : 2'b01);
        check("dut0_frame_len_left", q0.size(), 0);
      end
    end
  end

  always @(negedge clk) begin
    line_t e;
    if (busy1) begin
      if (q1.size() == 0) check("dut1_extra_busy_cycle", 1, 0);
      else begin
        e = q1.pop_front();
        check("dut1_tx_line", {30'd0, p1, m1}, {30'd0, e.p, e.m});
      end
    end
    if (done1 || abort1) begin
      if (ev1.size() == 0) check("dut1_unexpected_event", {done1, abort1}, 0);
      else begin
        int k;
        k = ev1.pop_front();
        check("dut1_event", {done1, abort1}, (k == EV_DONE) ? 2'b10 : 2'b01);
        check("dut1_frame_len_left", q1.size(), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int which, input int max_cyc, output int nbusy);
    bit seen;
    seen  = 1'b0;
    nbusy = 0;
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      if ((which == 0) ? done0 : done1) begin
        seen = 1'b1;
        break;
      end
      if ((which == 0) ? busy0 : busy1) nbusy++;
    end
    check("done_seen", {31'd0, seen}, 1);
  endtask

  int nb;
  int n;
  bit got;
  bit prev_done;

  initial begin
    reset = 1'b1; tx_en0 = 1'b1; rdy0 = 1'b1; msg0 = 32'h0182_0000;
    tx_en1 = 1'b0; rdy1 = 1'b0; msg1 = 8'h00;

    // Reset held with a pending request: nothing may come out.
    repeat (4) begin
      tick();
      check("rst_ack", ack0, 0);
      check("rst_busy", busy0, 0);
      check("rst_lines", {p0, m0}, 0);
      check("rst_pulses", {done0, abort0}, 0);
    end

    // Basic frame 01 82 00 00, checksum 83.
    push_frame(0, 32'h0182_0000, 4, 8'h83, 4, FULL);
    ev0.push_back(EV_DONE);
    reset = 1'b0;
    tick();
    check("ack_after_reset", ack0, 1);
    check("busy_after_load", busy0, 1);
    rdy0 = 1'b0;
    tick();
    check("ack_one_cycle", ack0, 0);
    wait_done(0, 300, nb);
    check("busy_cycles_200", nb + 2, 200);
    check("done_cycle_busy", busy0, 0);
    check("done_cycle_lines", {p0, m0}, 0);
    tick();
    check("done_one_cycle", done0, 0);

    // Back-to-back: second request held through frame A.
    msg0 = 32'hDEAD_BEEF; rdy0 = 1'b1;
    push_frame(0, 32'hDEAD_BEEF, 4, 8'h22, 4, FULL);
    ev0.push_back(EV_DONE);
    tick();
    check("ack_frame_a", ack0, 1);
    msg0 = 32'h1234_5678;
    n = 0; got = 1'b0; prev_done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      n++;
      if (ack0) begin
        got = 1'b1;
        push_frame(0, 32'h1234_5678, 4, 8'h08, 4, FULL);
        ev0.push_back(EV_DONE);
        break;
      end
      prev_done = done0;
    end
    check("ack_frame_b_seen", {31'd0, got}, 1);
    check("ack_b_after_done", {31'd0, prev_done}, 1);
    check("ack_b_latency", n, 201);
    rdy0 = 1'b0;
    wait_done(0, 300, nb);
    check("busy_cycles_frame_b", nb + 1, 200);

    // Abort: tx_en dropped in busy cycle 60.
    tick();
    msg0 = 32'hA5A5_0F0F; rdy0 = 1'b1;
    push_frame(0, 32'hA5A5_0F0F, 4, 8'h00, 4, 60);
    ev0.push_back(EV_ABORT);
    tick();
    check("ack_abort_frame", ack0, 1);
    rdy0 = 1'b0;
    repeat (59) tick();
    tx_en0 = 1'b0;
    tick();
    check("abort_pulse", abort0, 1);
    check("abort_busy", busy0, 0);
    check("abort_lines", {p0, m0}, 0);
    check("abort_no_done", done0, 0);
    rdy0 = 1'b1;
    repeat (3) begin
      tick();
      check("no_ack_tx_en_low", ack0, 0);
      check("abort_one_cycle", abort0, 0);
      check("idle_lines", {p0, m0}, 0);
    end
    rdy0 = 1'b0; tx_en0 = 1'b1;
    tick();

    // Reset in the middle of the payload, then a clean frame.
    msg0 = 32'h0000_0001; rdy0 = 1'b1;
    push_frame(0, 32'h0000_0001, 4, 8'h01, 4, 50);
    tick();
    check("ack_reset_frame", ack0, 1);
    rdy0 = 1'b0;
    repeat (49) tick();
    reset = 1'b1;
    tick();
    check("midrst_busy", busy0, 0);
    check("midrst_lines", {p0, m0}, 0);
    check("midrst_pulses", {ack0, done0, abort0}, 0);
    check("midrst_consumed", q0.size(), 0);
    reset = 1'b0;
    msg0 = 32'h5A3C_C301; rdy0 = 1'b1;
    push_frame(0, 32'h5A3C_C301, 4, 8'hA4, 4, FULL);
    ev0.push_back(EV_DONE);
    tick();
    check("ack_after_midrst", ack0, 1);
    rdy0 = 1'b0;
    wait_done(0, 300, nb);

    // One clock per bit, 8-bit all-ones payload: 26-cycle frame.
    msg1 = 8'hFF; rdy1 = 1'b1; tx_en1 = 1'b1;
    push_frame(1, 32'h0000_00FF, 1, 8'hFF, 1, FULL);
    ev1.push_back(EV_DONE);
    tick();
    check("dut1_ack", ack1, 1);
    rdy1 = 1'b0;
    wait_done(1, 60, nb);
    check("dut1_busy_cycles", nb + 1, 26);

    repeat (3) tick();
    check("dut0_queue_drained", q0.size() + ev0.size(), 0);
    check("dut1_queue_drained", q1.size() + ev1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
